// File: rtl/cmd_phys_gen.sv
// SD CMD-line PHY: serializes a command with CRC7, then optionally captures a
// short or long response, checks its CRC7/stop bit and hands it to the host.
module cmd_phys_gen #(
    parameter int CMD_W   = 40,
    parameter int RSP_W   = 136,
    parameter int NCR_MAX = 64,
    parameter int CNT_W   = 8
) (
    input  logic             sd_clock,
    input  logic             reset,
    input  logic             strobe_in,
    input  logic             ack_in,
    input  logic             idle_in,
    input  logic [1:0]       rsp_type,
    input  logic [CMD_W-1:0] cmd_to_send,
    output logic             ack_out,
    output logic             strobe_out,
    output logic [RSP_W-1:0] response,
    output logic             crc_err,
    output logic             timeout_err,
    inout  wire              cmd_pin
);

    typedef enum logic [2:0] {IDLE, SEND, TURN, WAIT, RECV, CHECK, DONE} state_t;

    localparam logic [CNT_W-1:0] DATA_END    = CNT_W'(CMD_W);
    localparam logic [CNT_W-1:0] FRAME_LAST  = CNT_W'(CMD_W + 7);
    localparam logic [CNT_W-1:0] TURN_LAST   = CNT_W'(1);
    localparam logic [CNT_W-1:0] NCR_LAST    = CNT_W'(NCR_MAX - 1);
    localparam logic [CNT_W-1:0] SHORT_LAST  = CNT_W'(47);
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(RSP_W - 1);
    localparam logic [CNT_W-1:0] SHORT_CRC_HI = CNT_W'(39);
    localparam logic [CNT_W-1:0] LONG_CRC_LO = CNT_W'(RSP_W - 128);
    localparam logic [CNT_W-1:0] LONG_CRC_HI = CNT_W'(RSP_W - 9);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CMD_W-1:0] tx_sh;
    logic [6:0]       crc;
    logic [1:0]       mode;
    logic [RSP_W-1:0] rx;
    logic             pin_in, drive, pin_val, accept, is_long;
    logic [CNT_W-1:0] rx_last, crc_lo, crc_hi;

    function automatic logic [6:0] crc_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = b ^ c[6];
        return {c[5:3], c[2] ^ fb, c[1:0], fb};
    endfunction

    assign pin_in     = cmd_pin;
    assign cmd_pin    = drive ? pin_val : 1'bz;
    assign strobe_out = (state == DONE);
    assign is_long    = (mode == 2'b10);
    assign rx_last    = is_long ? LONG_LAST : SHORT_LAST;
    assign crc_lo     = is_long ? LONG_CRC_LO : '0;
    assign crc_hi     = is_long ? LONG_CRC_HI : SHORT_CRC_HI;

    always_comb begin
        state_nxt = state;
        ack_out   = 1'b0;
        accept    = 1'b0;
        drive     = 1'b0;
        pin_val   = 1'b1;
        case (state)
            IDLE: if (strobe_in && !reset) begin
                accept    = 1'b1;
                ack_out   = 1'b1;
                state_nxt = SEND;
            end
            SEND: begin
                drive = 1'b1;
                if (cnt < DATA_END)        pin_val = tx_sh[CMD_W-1];
                else if (cnt < FRAME_LAST) pin_val = crc[6];
                if (cnt == FRAME_LAST) state_nxt = TURN;
            end
            TURN: begin
                drive = 1'b1;
                if (cnt == TURN_LAST) state_nxt = (mode == 2'b00) ? DONE : WAIT;
            end
            WAIT: begin
                if (!pin_in)              state_nxt = RECV;
                else if (cnt == NCR_LAST) state_nxt = DONE;
            end
            RECV:  if (cnt == rx_last) state_nxt = CHECK;
            CHECK: state_nxt = DONE;
            DONE:  if (ack_in) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (idle_in) begin
            state_nxt = IDLE;
            ack_out   = 1'b0;
            accept    = 1'b0;
        end
    end

    always_ff @(posedge sd_clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            tx_sh       <= '0;
            crc         <= '0;
            mode        <= '0;
            rx          <= '0;
            response    <= '0;
            crc_err     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (idle_in) begin
                cnt         <= '0;
                crc_err     <= 1'b0;
                timeout_err <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (accept) begin
                        tx_sh       <= cmd_to_send;
                        mode        <= rsp_type;
                        cnt         <= '0;
                        crc         <= '0;
                        crc_err     <= 1'b0;
                        timeout_err <= 1'b0;
                    end
                    SEND: begin
                        // data bits feed the CRC; afterwards the CRC itself shifts out
                        if (cnt < DATA_END) begin
                            tx_sh <= tx_sh << 1;
                            crc   <= crc_step(crc, tx_sh[CMD_W-1]);
                        end else begin
                            crc <= crc << 1;
                        end
                        cnt <= (cnt == FRAME_LAST) ? '0 : cnt + 1'b1;
                    end
                    TURN: cnt <= (cnt == TURN_LAST) ? '0 : cnt + 1'b1;
                    WAIT: begin
                        if (!pin_in) begin
                            // start bit is 0, so a cleared rx already holds it
                            rx  <= '0;
                            crc <= '0;
                            cnt <= CNT_W'(1);
                        end else if (cnt == NCR_LAST) begin
                            timeout_err <= 1'b1;
                            cnt         <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    RECV: begin
                        rx <= {rx[RSP_W-2:0], pin_in};
                        if (cnt >= crc_lo && cnt <= crc_hi) crc <= crc_step(crc, pin_in);
                        cnt <= cnt + 1'b1;
                    end
                    CHECK: begin
                        response <= rx;
                        crc_err  <= (mode != 2'b11) && ((crc != rx[7:1]) || !rx[0]);
                        cnt      <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/cmd_phys_gen.md
CMD_PHYS_GEN -- requirements
Module: cmd_phys_gen

Interface
REQ-001 Parameter CMD_W, default 40, command content width: start bit, transmission bit, 6-bit index and 32-bit argument.
REQ-002 Parameter RSP_W, default 136, long-response frame width; short responses are fixed at 48 bits.
REQ-003 Parameter NCR_MAX, default 64, number of cycles to wait for a response start bit before timeout.
REQ-004 Parameter CNT_W, default 8, width of the bit/cycle counter; it SHALL hold RSP_W and NCR_MAX.
REQ-005 sd_clock  in  1  the single clock; all logic is rising-edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 strobe_in  in  1  host command request.
REQ-008 ack_in  in  1  host acknowledges the response.
REQ-009 idle_in  in  1  abort; forces IDLE.
REQ-010 rsp_type  in  2  response mode: 00 none, 01 short with CRC, 10 long with CRC, 11 short without CRC check.
REQ-011 cmd_to_send  in  CMD_W  command content, MSB first.
REQ-012 ack_out  out  1  one-cycle pulse: command accepted.
REQ-013 strobe_out  out  1  result valid; held until ack_in.
REQ-014 response  out  RSP_W  received frame, right-aligned (a short frame occupies bits [47:0]; upper bits are 0).
REQ-015 crc_err  out  1  received CRC7 mismatch.
REQ-016 timeout_err  out  1  no start bit seen within NCR_MAX cycles.
REQ-017 cmd_pin  inout  1  SD CMD line; driven only in SEND and TURN, high-Z otherwise.

Function
REQ-018 States SHALL be IDLE, SEND, TURN, WAIT, RECV, CHECK and DONE.
REQ-019 IDLE with strobe_in=1 SHALL, in one clock: latch cmd_to_send and rsp_type, pulse ack_out, and enter SEND.
REQ-020 The transmit frame SHALL be {cmd_to_send, CRC7(cmd_to_send), 1'b1}: 48 bits shifted MSB first, one bit per cycle.
REQ-021 CRC7 SHALL use polynomial x^7+x^3+1 with initial value 0, computed serially on the bit stream.
REQ-022 The first frame bit SHALL appear on cmd_pin in the cycle after ack_out; SEND SHALL last exactly 48 cycles.
REQ-023 TURN SHALL drive cmd_pin high for 2 cycles, then release it.
REQ-024 After TURN: if rsp_type=00, go to DONE; otherwise go to WAIT.
REQ-025 WAIT SHALL sample cmd_pin each cycle:
- a 0 enters RECV, and that 0 counts as frame bit 1;
- after NCR_MAX cycles without a 0, set timeout_err=1 and go to DONE.
REQ-026 RECV SHALL shift in 48 (short) or RSP_W (long) bits in total, then go to CHECK.
REQ-027 CRC coverage in CHECK:
- short, mode 01: CRC7 over bits [47:8], compared with bits [7:1];
- long: CRC7 over bits [127:8], compared with bits [7:1];
- mode 11: no check.
REQ-028 A mismatch SHALL set crc_err=1. CHECK SHALL take 1 cycle and then go to DONE.
REQ-029 DONE SHALL hold strobe_out=1, with response, crc_err and timeout_err stable, until ack_in=1. It then returns to IDLE and clears strobe_out the next cycle.
REQ-030 strobe_in outside IDLE SHALL be ignored: no second ack_out is issued.
REQ-031 idle_in=1 in any state SHALL, next cycle: enter IDLE, release cmd_pin, clear strobe_out and both error flags, and retain response.
REQ-032 idle_in together with strobe_in in IDLE: idle_in SHALL win and no ack_out is issued.
REQ-033 A stop bit (bit 0) of 0 in a received frame SHALL set crc_err=1 for all modes except 11.

Reset
REQ-034 On reset=1, asynchronously:
- state = IDLE;
- ack_out, strobe_out, crc_err, timeout_err = 0;
- response = 0;
- counters and CRC registers = 0;
- cmd_pin at high-Z.
REQ-035 Reset asserted mid-SEND or mid-RECV SHALL abort immediately with no partial result.

Verification
REQ-036 CMD0: cmd_to_send=40'h4000000000, rsp_type=00 -> cmd_pin carries 48'h400000000095 over 48 cycles, then 2 high cycles; strobe_out=1 with both errors 0.
REQ-037 CMD8: cmd_to_send=40'h48000001AA, rsp_type=01; the bench returns 48'h08000001AA13 after a 5-cycle gap -> frame 48'h48000001AA87 sent; response[47:0]=48'h08000001AA13, crc_err=0.
REQ-038 Same as REQ-037, but the bench returns 48'h08000001AA15 -> crc_err=1, strobe_out=1.
REQ-039 rsp_type=10; the bench holds cmd_pin high -> timeout_err=1 exactly NCR_MAX cycles after TURN ends; strobe_out=1; response unchanged.
REQ-040 idle_in pulsed at bit 20 of SEND -> IDLE next cycle, cmd_pin high-Z, no strobe_out; a new strobe_in is accepted afterwards.
REQ-041 strobe_in held high through DONE; ack_in pulsed -> exactly one ack_out per transaction; a second command starts only after return to IDLE.
